quad_decoder: RTL and testbench

Quadrature (A/B) incremental-encoder decoder that turns two asynchronous phase inputs into the step/direction pair (CE-style pulse plus up/down mode) and a tracked position count. It generates the count-enable and direction controls that the team's up/down counters consume, and also maintains its own loadable, wrapping position register with a wrap pulse. It sits at the I/O boundary, between the encoder pins and the counting/control logic.

---
 rtl/quad_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_quad_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// ---------------------------------------------------------------------------
// quad_decoder
//
// Quadrature (A/B) incremental-encoder decoder. Both phases are synchronized,
// optionally glitch-filtered, then decoded 4x into a STEP pulse, a DIR level
// and a loadable, wrapping position count with a WRAP pulse. An illegal
// transition (both phases change at once) sets a sticky ERR flag.
//
// Build option:
//   QDEC_FILTER_EN - when defined, each synchronized phase goes through a
//                    stability filter of FILT_CYCLES cycles before decoding.
//
// Parameters:
//   WIDTH        position register width (>= 2)
//   FILT_CYCLES  filter stability cycles (>= 1, used with QDEC_FILTER_EN)
//
// Ports:
//   CLK   in   system clock, rising edge
//   RST_  in   asynchronous active-low reset
//   A, B  in   encoder phases, asynchronous to CLK
//   LD    in   synchronous load of POS from D (wins over a step)
//   D     in   load value
//   CLR   in   synchronous clear of ERR (a same-cycle error wins)
//   STEP  out  one-cycle pulse per valid transition
//   DIR   out  direction of last valid step (0 = up, 1 = down)
//   POS   out  position count, modulo 2^WIDTH
//   WRAP  out  one-cycle pulse when POS wraps max->0 or 0->max
//   ERR   out  sticky illegal-transition flag
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module quad_decoder #(
   parameter int WIDTH       = 8,
   parameter int FILT_CYCLES = 4
) (
   input  logic             CLK,
   input  logic             RST_,
   input  logic             A,
   input  logic             B,
   input  logic             LD,
   input  logic [WIDTH-1:0] D,
   input  logic             CLR,
   output logic             STEP,
   output logic             DIR,
   output logic [WIDTH-1:0] POS,
   output logic             WRAP,
   output logic             ERR
);

   typedef enum logic {
      ST_INIT,
      ST_TRACK
   } state_t;

   // Settle counter is sized for the filtered build so its width does not
   // change with the build option.
   localparam int SETTLE_MAX = 2 + FILT_CYCLES;
   localparam int SW         = $clog2(SETTLE_MAX + 1);

   // Gray position within the up sequence 00->01->11->10.
   function automatic logic [1:0] gray2bin(input logic [1:0] g);
      return {g[1], g[1] ^ g[0]};
   endfunction

   // ------------------------------------------------------------------------
   // Two-flop synchronizer, bit 1 = A, bit 0 = B
   // ------------------------------------------------------------------------
   logic [1:0] r_meta;
   logic [1:0] r_sync;

   // NOTE: clocked state is written only with non-blocking assignments so
   // every flop samples the pre-edge value of every other flop.
   always_ff @(posedge CLK or negedge RST_) begin
      if (!RST_) begin
         r_meta <= 2'b00;
         r_sync <= 2'b00;
      end else begin
         r_meta <= {A, B};
         r_sync <= r_meta;
      end
   end

   logic [1:0] w_s;

`ifdef QDEC_FILTER_EN
   // ------------------------------------------------------------------------
   // Per-phase stability filter: the filtered level follows the synchronized
   // level only after it has differed for FILT_CYCLES consecutive cycles.
   // ------------------------------------------------------------------------
   localparam int              FCW       = $clog2(FILT_CYCLES + 1);
   localparam logic [FCW-1:0]  FILT_LAST = FCW'(FILT_CYCLES - 1);
   localparam logic [SW-1:0]   SETTLE_V  = SW'(2 + FILT_CYCLES);

   logic [FCW-1:0] r_fcnt [2];
   logic [1:0]     r_filt;

   always_ff @(posedge CLK or negedge RST_) begin
      if (!RST_) begin
         r_filt <= 2'b00;
         for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (r_sync[i] == r_filt[i]) begin
               r_fcnt[i] <= '0;
            end else if (r_fcnt[i] == FILT_LAST) begin
               r_filt[i] <= r_sync[i];
               r_fcnt[i] <= '0;
            end else begin
               r_fcnt[i] <= r_fcnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_s = r_filt;
`else
   localparam logic [SW-1:0] SETTLE_V = SW'(2);

   assign w_s = r_sync;
`endif

   // ------------------------------------------------------------------------
   // Decoder FSM and output registers
   // ------------------------------------------------------------------------
   state_t           r_state, w_state_nxt;
   logic [1:0]       r_prev, w_prev_nxt;
   logic [SW-1:0]    r_settle, w_settle_nxt;
   logic             r_step, w_step_nxt;
   logic             r_dir, w_dir_nxt;
   logic [WIDTH-1:0] r_pos, w_pos_nxt;
   logic             r_wrap, w_wrap_nxt;
   logic             r_err, w_err_nxt;
   logic             w_illegal;
   logic [1:0]       w_delta;

   // 1 = one step up, 3 = one step down, 2 = both phases changed, 0 = idle.
   assign w_delta = gray2bin(w_s) - gray2bin(r_prev);

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt  = r_state;
      w_prev_nxt   = r_prev;
      w_settle_nxt = r_settle;
      w_step_nxt   = 1'b0;
      w_dir_nxt    = r_dir;
      w_pos_nxt    = r_pos;
      w_wrap_nxt   = 1'b0;
      w_illegal    = 1'b0;

      unique case (r_state)
         ST_INIT: begin
            // Wait until the synchronizer (and filter) hold real pin levels,
            // then take them as the reference without counting.
            if (r_settle == SETTLE_V) begin
               w_prev_nxt  = w_s;
               w_state_nxt = ST_TRACK;
            end else begin
               w_settle_nxt = r_settle + 1'b1;
            end
         end
         ST_TRACK: begin
            unique case (w_delta)
               2'd1: begin
                  w_step_nxt = 1'b1;
                  w_dir_nxt  = 1'b0;
                  w_pos_nxt  = r_pos + 1'b1;
                  w_wrap_nxt = &r_pos;
                  w_prev_nxt = w_s;
               end
               2'd3: begin
                  w_step_nxt = 1'b1;
                  w_dir_nxt  = 1'b1;
                  w_pos_nxt  = r_pos - 1'b1;
                  w_wrap_nxt = ~|r_pos;
                  w_prev_nxt = w_s;
               end
               2'd2: begin
                  w_illegal  = 1'b1;
                  w_prev_nxt = w_s;
               end
               default: ;
            endcase
         end
         default: w_state_nxt = ST_INIT;
      endcase

      // Load owns POS; the step is still reported but cannot wrap.
      if (LD) begin
         w_pos_nxt  = D;
         w_wrap_nxt = 1'b0;
      end

      if (w_illegal)  w_err_nxt = 1'b1;
      else if (CLR)   w_err_nxt = 1'b0;
      else            w_err_nxt = r_err;
   end

   // NOTE: all control and datapath registers here take an asynchronous
   // reset; there is no storage array whose contents could be left unreset.
   always_ff @(posedge CLK or negedge RST_) begin
      if (!RST_) begin
         r_state  <= ST_INIT;
         r_prev   <= 2'b00;
         r_settle <= '0;
         r_step   <= 1'b0;
         r_dir    <= 1'b0;
         r_pos    <= '0;
         r_wrap   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_prev   <= w_prev_nxt;
         r_settle <= w_settle_nxt;
         r_step   <= w_step_nxt;
         r_dir    <= w_dir_nxt;
         r_pos    <= w_pos_nxt;
         r_wrap   <= w_wrap_nxt;
         r_err    <= w_err_nxt;
      end
   end

   assign STEP = r_step;
   assign DIR  = r_dir;
   assign POS  = r_pos;
   assign WRAP = r_wrap;
   assign ERR  = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// ---------------------------------------------------------------------------
// tb_quad_decoder
//
// Directed bench for quad_decoder (WIDTH=8). Each driven valid transition
// pushes the expected STEP event (cycle, DIR, POS, WRAP) into a queue; a
// negedge monitor pops and compares whenever STEP is seen. Level checks of
// ERR/POS/WRAP and reset values are made directly by the stimulus process.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_quad_decoder;

   localparam int WIDTH = 8;
   localparam int FILT  = 4;
`ifdef QDEC_FILTER_EN
   localparam int LAT   = 3 + FILT;
`else
   localparam int LAT   = 3;
`endif

   logic             CLK  = 1'b0;
   logic             RST_ = 1'b0;
   logic             A    = 1'b0;
   logic             B    = 1'b0;
   logic             LD   = 1'b0;
   logic             CLR  = 1'b0;
   logic [WIDTH-1:0] D    = '0;
   logic             STEP, DIR, WRAP, ERR;
   logic [WIDTH-1:0] POS;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int               cyc;
      logic             dir;
      logic [WIDTH-1:0] pos;
      logic             wrap;
   } exp_t;

   exp_t exp_q[$];

   quad_decoder #(.WIDTH(WIDTH), .FILT_CYCLES(FILT)) dut (
      .CLK  (CLK),
      .RST_ (RST_),
      .A    (A),
      .B    (B),
      .LD   (LD),
      .D    (D),
      .CLR  (CLR),
      .STEP (STEP),
      .DIR  (DIR),
      .POS  (POS),
      .WRAP (WRAP),
      .ERR  (ERR)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor
   always @(negedge CLK) begin
      if (RST_) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("step_missing_at_cycle", 32'(cyc), 32'(exp_q[0].cyc));
            void'(exp_q.pop_front());
         end
         if (STEP) begin
            if (exp_q.size() == 0) begin
               check("unexpected_step", {31'd0, STEP}, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("step_cycle", 32'(cyc), 32'(e.cyc));
               check("step_dir",   {31'd0, DIR}, {31'd0, e.dir});
               check("step_pos",   {24'd0, POS}, {24'd0, e.pos});
               check("step_wrap",  {31'd0, WRAP}, {31'd0, e.wrap});
            end
         end else if (WRAP) begin
            check("wrap_without_step", {31'd0, WRAP}, 32'd0);
         end
      end
   end

   // Leaves the caller 1 ns after the n-th following rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Drive a valid transition and queue the step it must produce.
   task automatic step_to(input logic [1:0] ab, input logic dir,
                          input logic [WIDTH-1:0] pos, input logic wrap);
      exp_t e;
      {A, B} = ab;
      e.cyc  = cyc + LAT;
      e.dir  = dir;
      e.pos  = pos;
      e.wrap = wrap;
      exp_q.push_back(e);
   endtask

   // Asynchronous reset mid-cycle, immediate output check, release, settle.
   task automatic do_reset(input logic [1:0] ab);
      check("queue_drained_before_reset", 32'(exp_q.size()), 32'd0);
      @(posedge CLK);
      #3;
      RST_   = 1'b0;
      {A, B} = ab;
      LD     = 1'b0;
      CLR    = 1'b0;
      #1;
      check("rst_step", {31'd0, STEP}, 32'd0);
      check("rst_dir",  {31'd0, DIR},  32'd0);
      check("rst_pos",  {24'd0, POS},  32'd0);
      check("rst_wrap", {31'd0, WRAP}, 32'd0);
      check("rst_err",  {31'd0, ERR},  32'd0);
      tick(3);
      RST_ = 1'b1;
      tick(LAT + 8);
   endtask

   initial begin
      // Reset with both phases high: INIT must capture 11 silently.
      do_reset(2'b11);
      check("init11_err",  {31'd0, ERR},  32'd0);
      check("init11_pos",  {24'd0, POS},  32'd0);
      check("init11_dir",  {31'd0, DIR},  32'd0);
      check("init11_step", {31'd0, STEP}, 32'd0);

      // Up count from 00.
      do_reset(2'b00);
      step_to(2'b01, 1'b0, 8'd1, 1'b0); tick(4);
      step_to(2'b11, 1'b0, 8'd2, 1'b0); tick(4);
      step_to(2'b10, 1'b0, 8'd3, 1'b0); tick(4);
      step_to(2'b00, 1'b0, 8'd4, 1'b0); tick(LAT + 2);
      check("up_pos", {24'd0, POS}, 32'd4);

      // Down from 0 wraps to 255; WRAP lasts exactly one cycle.
      do_reset(2'b00);
      step_to(2'b10, 1'b1, 8'hFF, 1'b1);
      tick(LAT);
      check("down_wrap_high", {31'd0, WRAP}, 32'd1);
      tick(1);
      check("down_wrap_one_cycle", {31'd0, WRAP}, 32'd0);
      check("down_step_one_cycle", {31'd0, STEP}, 32'd0);

      // Up from 255 wraps to 0.
      step_to(2'b00, 1'b0, 8'h00, 1'b1); tick(LAT + 2);

      // Illegal 00 -> 11.
      {A, B} = 2'b11;
      tick(LAT);
      check("illegal_err", {31'd0, ERR}, 32'd1);
      check("illegal_pos", {24'd0, POS}, 32'd0);
      check("illegal_dir", {31'd0, DIR}, 32'd0);
      CLR = 1'b1;
      tick(1);
      CLR = 1'b0;
      check("clr_err", {31'd0, ERR}, 32'd0);

      // CLR coincident with an illegal 11 -> 00: set wins.
      {A, B} = 2'b00;
      tick(LAT - 1);
      check("err_before_clr", {31'd0, ERR}, 32'd0);
      CLR = 1'b1;
      tick(1);
      CLR = 1'b0;
      check("set_wins_err", {31'd0, ERR}, 32'd1);
      tick(2);

      // Load coincident with an up step: POS takes D, STEP still reported.
      step_to(2'b01, 1'b0, 8'h7F, 1'b0);
      tick(LAT - 1);
      LD = 1'b1;
      D  = 8'h7F;
      tick(1);
      LD = 1'b0;
      check("err_sticky_while_counting", {31'd0, ERR}, 32'd1);
      tick(2);

      // Decoding continues with ERR set.
      step_to(2'b11, 1'b0, 8'h80, 1'b0); tick(4);
      step_to(2'b01, 1'b1, 8'h7F, 1'b0); tick(4);

      // Plain load, then load over a would-be wrapping up step.
      LD = 1'b1;
      D  = 8'hFF;
      tick(1);
      LD = 1'b0;
      check("load_pos", {24'd0, POS}, 32'hFF);
      step_to(2'b11, 1'b0, 8'h10, 1'b0);
      tick(LAT - 1);
      LD = 1'b1;
      D  = 8'h10;
      tick(1);
      LD = 1'b0;
      tick(2);

      // Steps on consecutive cycles give back-to-back pulses.
      step_to(2'b10, 1'b0, 8'h11, 1'b0); tick(1);
      step_to(2'b00, 1'b0, 8'h12, 1'b0); tick(LAT + 3);
      step_to(2'b10, 1'b1, 8'h11, 1'b0); tick(LAT + 2);
      check("after_b2b_pos", {24'd0, POS}, 32'h11);

`ifdef QDEC_FILTER_EN
      // Two-cycle glitch on A is discarded; a long level change counts once.
      {A, B} = 2'b00;
      tick(2);
      {A, B} = 2'b10;
      tick(LAT + 4);
      check("glitch_pos", {24'd0, POS}, 32'h11);
      step_to(2'b00, 1'b0, 8'h12, 1'b0);
      tick(LAT + 3);
      check("filtered_pos", {24'd0, POS}, 32'h12);
`endif

      // Final asynchronous reset mid-operation.
      do_reset(2'b00);
      check("queue_drained_at_end", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
